// File: rtl/core_prefetch_queue_pkg.sv
// Shared types and defaults for the instruction prefetch path.
// Provides word/halfword/pointer types, the NOP encodings used to pad
// empty or split pairs, and core-wide queue sizing defaults.
package core_prefetch_queue_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned HWORD_W = 16;
  localparam int unsigned PTR_W   = 30;  // word address
  localparam int unsigned HPTR_W  = 31;  // {word address, half bit}

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [HWORD_W-1:0] hword_t;
  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [HPTR_W-1:0]  hptr_t;

  localparam hword_t NOP  = 16'h0001;
  localparam word_t  DNOP = {NOP, NOP};

  localparam int unsigned PREFETCH_DEPTH   = 4;
  localparam int unsigned PREFETCH_MAX_OUT = 2;

  function automatic hptr_t make_hptr(input ptr_t word_addr, input logic half);
    return {word_addr, half};
  endfunction

endpackage

// File: rtl/core_prefetch_credit.sv
// Request/discard credit tracker for the prefetch queue.
// Holds the number of granted-but-unreturned fetches and the number of
// returning responses that belong to a flushed stream and must be dropped.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush         redirect this cycle; suppresses requests and drops responses
//   count         current queue occupancy
//   fetch_gnt     bus accepted the request this cycle
//   fetch_rvalid  response word arriving this cycle
//   fetch_req     request valid towards the bus
//   push          the arriving response belongs to the live stream
module core_prefetch_credit #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [$clog2(DEPTH):0] count,
  input  logic                   fetch_gnt,
  input  logic                   fetch_rvalid,
  output logic                   fetch_req,
  output logic                   push
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C   = DEPTH[CW:0];
  localparam logic [CW-1:0] MAX_OUT_C = MAX_OUT[CW-1:0];

  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW:0]   credit_used;
  logic          gnt, rsp, drop;

  // Queue space is reserved at grant time, so a push can never overflow.
  assign credit_used = {1'b0, count} + {1'b0, out_q};
  assign fetch_req   = !flush && (credit_used < DEPTH_C) && (out_q < MAX_OUT_C);

  assign gnt  = fetch_req && fetch_gnt;
  // A response with nothing outstanding is a bus protocol error and is ignored.
  assign rsp  = fetch_rvalid && (out_q != '0);
  assign drop = rsp && (flush || (disc_q != '0));
  assign push = rsp && !drop;

  always_comb begin
    out_d = out_q;
    if (gnt && !rsp) begin
      out_d = out_q + CW'(1);
    end else if (!gnt && rsp) begin
      out_d = out_q - CW'(1);
    end

    disc_d = disc_q;
    if (flush) begin
      // Every request still in flight after this cycle belongs to the old
      // stream; this already includes any discards still pending.
      disc_d = out_d;
    end else if (rsp && (disc_q != '0)) begin
      disc_d = disc_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      disc_q <= '0;
    end else begin
      out_q  <= out_d;
      disc_q <= disc_d;
    end
  end

  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (rst)
    !(fetch_rvalid && (out_q == '0)));

endmodule

// File: rtl/core_prefetch_queue.sv
// Instruction prefetch queue between the fetch bus port and decode.
// Issues word fetches ahead of decode, buffers returned words in a circular
// queue and presents the head word as a halfword instruction pair.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   stall                    decode not accepting; hold the current pair
//   flush, head              redirect to halfword pointer head (highest priority)
//   fetch_req/addr/gnt       request channel (word addresses)
//   fetch_rvalid/rdata       in-order response channel
//   hi_insn, lo_insn         instruction pair, lo executes first
//   hi_insn_pc, lo_insn_pc   halfword PCs of the pair
//   pair_pc, pair_valid      word address of head entry and its validity
//   level                    occupied entries
module core_prefetch_queue
  import core_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = PREFETCH_DEPTH,
  parameter int unsigned MAX_OUT = PREFETCH_MAX_OUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  hptr_t                  head,
  output logic                   fetch_req,
  output ptr_t                   fetch_addr,
  input  logic                   fetch_gnt,
  input  logic                   fetch_rvalid,
  input  word_t                  fetch_rdata,
  output hword_t                 hi_insn,
  output hword_t                 lo_insn,
  output hptr_t                  hi_insn_pc,
  output hptr_t                  lo_insn_pc,
  output ptr_t                   pair_pc,
  output logic                   pair_valid,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  word_t         mem [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  ptr_t          req_addr_q, req_addr_d;
  ptr_t          pair_pc_q, pair_pc_d;
  logic          split_q, split_d;
  logic          push, pop, gnt;
  word_t         head_word;

  core_prefetch_credit #(
    .DEPTH   (DEPTH),
    .MAX_OUT (MAX_OUT)
  ) u_credit (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .count        (count_q),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_req    (fetch_req),
    .push         (push)
  );

  assign gnt = fetch_req && fetch_gnt;
  assign pop = !stall && !flush && (count_q != '0);

  always_comb begin
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    req_addr_d = req_addr_q;
    pair_pc_d  = pair_pc_q;
    split_d    = split_q;
    if (flush) begin
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
      req_addr_d = head[HPTR_W-1:1];
      pair_pc_d  = head[HPTR_W-1:1];
      split_d    = head[0];
    end else begin
      if (gnt) begin
        req_addr_d = req_addr_q + ptr_t'(1);
      end
      if (push) begin
        wr_d = wr_q + AW'(1);  // wraps modulo DEPTH (power of two)
      end
      if (pop) begin
        rd_d      = rd_q + AW'(1);
        pair_pc_d = pair_pc_q + ptr_t'(1);
        split_d   = 1'b0;
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      req_addr_q <= '0;
      pair_pc_q  <= '0;
      split_q    <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      req_addr_q <= req_addr_d;
      pair_pc_q  <= pair_pc_d;
      split_q    <= split_d;
    end
  end

  // Storage needs no reset: an empty queue always presents DNOP.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q] <= fetch_rdata;
    end
  end

  assign head_word = mem[rd_q];

  always_comb begin
    hi_insn    = head_word[WORD_W-1:HWORD_W];
    lo_insn    = head_word[HWORD_W-1:0];
    lo_insn_pc = make_hptr(pair_pc_q, 1'b0);
    hi_insn_pc = make_hptr(pair_pc_q, 1'b1);
    pair_valid = (count_q != '0);
    // Redirect into the upper half: only the hi halfword is a real insn.
    if (split_q) begin
      lo_insn    = head_word[WORD_W-1:HWORD_W];
      hi_insn    = NOP;
      lo_insn_pc = make_hptr(pair_pc_q, 1'b1);
    end
    if (flush || (count_q == '0)) begin
      {hi_insn, lo_insn} = DNOP;
      pair_valid         = 1'b0;
    end
  end

  assign fetch_addr = req_addr_q;
  assign pair_pc    = pair_pc_q;
  assign level      = count_q;

endmodule

// File: tb/tb_core_prefetch_queue.sv
module tb_core_prefetch_queue;

  localparam logic [15:0] TB_NOP = 16'h0001;

  logic        clk, rst, stall, flush;
  logic [30:0] head;
  logic        fetch_req, fetch_gnt, fetch_rvalid;
  logic [29:0] fetch_addr, pair_pc;
  logic [31:0] fetch_rdata;
  logic [15:0] hi_insn, lo_insn;
  logic [30:0] hi_insn_pc, lo_insn_pc;
  logic        pair_valid;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 2;
  logic [29:0] pend_addr[$];
  int          pend_due[$];

  core_prefetch_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .head         (head),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .hi_insn      (hi_insn),
    .lo_insn      (lo_insn),
    .hi_insn_pc   (hi_insn_pc),
    .lo_insn_pc   (lo_insn_pc),
    .pair_pc      (pair_pc),
    .pair_valid   (pair_valid),
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] hi_of(input logic [29:0] a);
    return {4'h1, a[11:0]};
  endfunction
  function automatic logic [15:0] lo_of(input logic [29:0] a);
    return {4'h2, a[11:0]};
  endfunction

  // One cycle of the in-order bus model: responses return `lat` cycles after grant.
  task automatic step();
    if (fetch_req && fetch_gnt) begin
      pend_addr.push_back(fetch_addr);
      pend_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend_due.size() != 0 && pend_due[0] == cyc) begin
      fetch_rvalid = 1'b1;
      fetch_rdata  = {hi_of(pend_addr[0]), lo_of(pend_addr[0])};
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      fetch_rvalid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; stall = 1'b0; fetch_gnt = 1'b0;
    fetch_rvalid = 1'b0; fetch_rdata = '0; head = '0;
    pend_addr.delete();
    pend_due.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall = 1'b0; fetch_gnt = 1'b0;
    fetch_rvalid = 1'b0; fetch_rdata = '0; head = '0;
    @(posedge clk); #1;
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b want 1", fetch_req); end
    checks++; if (fetch_addr !== 30'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", fetch_addr); end
    checks++; if ({hi_insn, lo_insn} !== {TB_NOP, TB_NOP}) begin errors++; $display("FAIL reset_insn: got %h want %h", {hi_insn, lo_insn}, {TB_NOP, TB_NOP}); end
    checks++; if (pair_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pair_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (pair_pc !== 30'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", pair_pc); end
    checks++; if ({lo_insn_pc, hi_insn_pc} !== {31'd0, 31'd1}) begin errors++; $display("FAIL reset_insn_pc: got %h/%h want 0/1", lo_insn_pc, hi_insn_pc); end
  endtask

  task automatic test_flush_redirect();
    do_reset();
    fetch_gnt = 1'b1;
    flush = 1'b1; head = {30'h55, 1'b0}; #1;
    checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL flush_req_low: got %b want 0", fetch_req); end
    step();
    flush = 1'b0; #1;
    checks++; if (fetch_addr !== 30'h55) begin errors++; $display("FAIL flush_addr: got %h want 55", fetch_addr); end
    checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL flush_req_after: got %b want 1", fetch_req); end
    checks++; if (pair_pc !== 30'h55) begin errors++; $display("FAIL flush_pair_pc: got %h want 55", pair_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 2; fetch_gnt = 1'b1;
    checks++; if (fetch_addr !== 30'd0) begin errors++; $display("FAIL stream_addr0: got %h want 0", fetch_addr); end
    step();
    checks++; if (fetch_addr !== 30'd1 || fetch_req !== 1'b1) begin errors++; $display("FAIL stream_addr1: got %h/%b want 1/1", fetch_addr, fetch_req); end
    step();  // c2: first response on the bus
    checks++; if (fetch_req !== 1'b0 || pair_valid !== 1'b0) begin errors++; $display("FAIL stream_c2: got req %b valid %b want 0 0", fetch_req, pair_valid); end
    step();  // c3
    checks++; if (pair_valid !== 1'b1 || pair_pc !== 30'd0) begin errors++; $display("FAIL stream_first_pair: got valid %b pc %h want 1 0", pair_valid, pair_pc); end
    checks++; if (lo_insn !== lo_of(30'd0) || hi_insn !== hi_of(30'd0)) begin errors++; $display("FAIL stream_word0: got %h/%h want %h/%h", hi_insn, lo_insn, hi_of(30'd0), lo_of(30'd0)); end
    checks++; if (fetch_addr !== 30'd2) begin errors++; $display("FAIL stream_addr2: got %h want 2", fetch_addr); end
    step();  // c4
    checks++; if (pair_pc !== 30'd1 || lo_insn !== lo_of(30'd1)) begin errors++; $display("FAIL stream_pair1: got pc %h lo %h want 1 %h", pair_pc, lo_insn, lo_of(30'd1)); end
    step();  // c5
    checks++; if (pair_valid !== 1'b0) begin errors++; $display("FAIL stream_gap: got %b want 0", pair_valid); end
    step();  // c6
    checks++; if (pair_pc !== 30'd2 || lo_insn !== lo_of(30'd2) || pair_valid !== 1'b1) begin errors++; $display("FAIL stream_pair2: got pc %h lo %h want 2 %h", pair_pc, lo_insn, lo_of(30'd2)); end
  endtask

  task automatic test_stall_full();
    do_reset();
    lat = 2; fetch_gnt = 1'b1; stall = 1'b1;
    repeat (7) step();
    checks++; if (level !== 3'd4 || fetch_req !== 1'b0) begin errors++; $display("FAIL full_level: got level %0d req %b want 4 0", level, fetch_req); end
    checks++; if (lo_insn !== lo_of(30'd0) || pair_pc !== 30'd0) begin errors++; $display("FAIL full_head: got lo %h pc %h want %h 0", lo_insn, pair_pc, lo_of(30'd0)); end
    repeat (3) step();
    checks++; if (level !== 3'd4 || hi_insn !== hi_of(30'd0) || fetch_req !== 1'b0) begin errors++; $display("FAIL full_hold: got level %0d hi %h req %b", level, hi_insn, fetch_req); end
    fetch_gnt = 1'b0; stall = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pair_valid !== 1'b1 || pair_pc !== 30'(i) || lo_insn !== lo_of(30'(i)) || hi_insn !== hi_of(30'(i))) begin
        errors++; $display("FAIL drain_%0d: got valid %b pc %h pair %h/%h", i, pair_valid, pair_pc, hi_insn, lo_insn);
      end
      step();
    end
    checks++; if (level !== 3'd0 || pair_valid !== 1'b0 || {hi_insn, lo_insn} !== {TB_NOP, TB_NOP}) begin errors++; $display("FAIL drain_empty: got level %0d valid %b pair %h", level, pair_valid, {hi_insn, lo_insn}); end
  endtask

  task automatic test_push_pop_wrap();
    do_reset();
    lat = 2; fetch_gnt = 1'b1; stall = 1'b1;
    repeat (6) step();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL wrap_pre: got %0d want 3", level); end
    stall = 1'b0;
    step();  // c7: push and pop together at level 3
    checks++; if (level !== 3'd3 || pair_pc !== 30'd1 || lo_insn !== lo_of(30'd1)) begin errors++; $display("FAIL wrap_same: got level %0d pc %h lo %h", level, pair_pc, lo_insn); end
    repeat (2) step();  // c9: rd_ptr at 3
    checks++; if (level !== 3'd1 || pair_pc !== 30'd3 || lo_insn !== lo_of(30'd3)) begin errors++; $display("FAIL wrap_rd3: got level %0d pc %h lo %h", level, pair_pc, lo_insn); end
    step();  // c10: rd_ptr wrapped to 0
    checks++; if (level !== 3'd1 || pair_pc !== 30'd4 || lo_insn !== lo_of(30'd4) || hi_insn !== hi_of(30'd4)) begin errors++; $display("FAIL wrap_rd0: got level %0d pc %h pair %h/%h", level, pair_pc, hi_insn, lo_insn); end
  endtask

  task automatic test_flush_split();
    do_reset();
    lat = 3; fetch_gnt = 1'b1;
    repeat (2) step();  // c2: two outstanding, no response yet
    flush = 1'b1; head = {30'h100, 1'b1}; #1;
    checks++; if (pair_valid !== 1'b0 || {hi_insn, lo_insn} !== {TB_NOP, TB_NOP} || fetch_req !== 1'b0) begin errors++; $display("FAIL split_flush: got valid %b pair %h req %b", pair_valid, {hi_insn, lo_insn}, fetch_req); end
    step();
    flush = 1'b0; #1;
    checks++; if (fetch_addr !== 30'h100) begin errors++; $display("FAIL split_addr: got %h want 100", fetch_addr); end
    step();  // c4
    checks++; if (pair_valid !== 1'b0) begin errors++; $display("FAIL split_drop0: got %b want 0", pair_valid); end
    step();  // c5
    checks++; if (pair_valid !== 1'b0) begin errors++; $display("FAIL split_drop1: got %b want 0", pair_valid); end
    repeat (3) step();  // c8
    checks++; if (pair_valid !== 1'b1 || lo_insn !== hi_of(30'h100) || hi_insn !== TB_NOP) begin errors++; $display("FAIL split_pair: got valid %b pair %h/%h want 1 %h/%h", pair_valid, hi_insn, lo_insn, TB_NOP, hi_of(30'h100)); end
    checks++; if (lo_insn_pc !== {30'h100, 1'b1} || pair_pc !== 30'h100) begin errors++; $display("FAIL split_pc: got lo_pc %h pc %h want %h 100", lo_insn_pc, pair_pc, {30'h100, 1'b1}); end
    step();  // c9
    checks++; if (lo_insn !== lo_of(30'h101) || hi_insn !== hi_of(30'h101) || lo_insn_pc !== {30'h101, 1'b0} || hi_insn_pc !== {30'h101, 1'b1}) begin errors++; $display("FAIL split_next: got %h/%h pcs %h/%h", hi_insn, lo_insn, hi_insn_pc, lo_insn_pc); end
  endtask

  task automatic test_flush_same_cycle();
    do_reset();
    lat = 2; fetch_gnt = 1'b1;
    repeat (2) step();  // c2: response for word 0 on the bus, one more outstanding
    checks++; if (fetch_rvalid !== 1'b1) begin errors++; $display("FAIL same_setup: rvalid %b want 1", fetch_rvalid); end
    flush = 1'b1; head = {30'h40, 1'b0}; #1;
    step();
    flush = 1'b0; #1;
    checks++; if (fetch_addr !== 30'h40 || fetch_req !== 1'b1) begin errors++; $display("FAIL same_req: got %h/%b want 40/1", fetch_addr, fetch_req); end
    step();  // c4
    checks++; if (pair_valid !== 1'b0) begin errors++; $display("FAIL same_drop0: got %b want 0", pair_valid); end
    step();  // c5
    checks++; if (pair_valid !== 1'b0) begin errors++; $display("FAIL same_drop1: got %b want 0", pair_valid); end
    step();  // c6
    checks++; if (pair_valid !== 1'b1 || pair_pc !== 30'h40 || lo_insn !== lo_of(30'h40) || hi_insn !== hi_of(30'h40)) begin errors++; $display("FAIL same_new0: got valid %b pc %h pair %h/%h", pair_valid, pair_pc, hi_insn, lo_insn); end
    step();  // c7
    checks++; if (pair_pc !== 30'h41 || lo_insn !== lo_of(30'h41)) begin errors++; $display("FAIL same_new1: got pc %h lo %h", pair_pc, lo_insn); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 2; fetch_gnt = 1'b1; stall = 1'b1;
    repeat (6) step();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_pre: got %0d want 3", level); end
    rst = 1'b1; #1;
    checks++; if (level !== 3'd0 || pair_valid !== 1'b0 || {hi_insn, lo_insn} !== {TB_NOP, TB_NOP}) begin errors++; $display("FAIL mid_out: got level %0d valid %b pair %h", level, pair_valid, {hi_insn, lo_insn}); end
    checks++; if (fetch_req !== 1'b1 || fetch_addr !== 30'd0 || pair_pc !== 30'd0) begin errors++; $display("FAIL mid_req: got req %b addr %h pc %h", fetch_req, fetch_addr, pair_pc); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_flush_redirect();
    test_stream();
    test_stall_full();
    test_push_pop_wrap();
    test_flush_split();
    test_flush_same_cycle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
